// File: rtl/package_settings.sv
// Project-wide settings shared by every block of the v12 shaping chain.
// Latency: none (constants only).
// Backpressure: none (no ports).
package package_settings;

    // ADC sample width consumed by the shaping filter.
    localparam int SIZE_ADC_DATA = 12;

endpackage

// File: rtl/v12_pulse_gen_pkg.sv
// Default constants and shared types for the v12 synthetic pulse source.
// Latency: none (constants and types only).
// Backpressure: none (no ports).
package v12_pulse_gen_parameters;

    import package_settings::*;

    // Fractional bits carried below the output LSB in the decay accumulator.
    localparam int FRAC_BITS   = 8;
    // Per-cycle decay is acc >> DECAY_SHIFT, giving tau of about 2^DECAY_SHIFT cycles.
    localparam int DECAY_SHIFT = 4;
    // Idle cycles forced after every accepted trigger.
    localparam int HOLDOFF     = 8;
    // Constant offset added to every output sample.
    localparam int BASELINE    = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pg_state_t;

    typedef logic [SIZE_ADC_DATA+FRAC_BITS-1:0] pg_acc_t;

endpackage

// File: rtl/v12_pulse_gen_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) used as a cheap noise source.
// Latency: new value one cycle after each enabled edge.
// Backpressure: none; advances whenever en is high.
module v12_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] state
);

    // Right-shifting Galois form: feedback mask 0xB400 encodes taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEED;
        end else if (en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/v12_pulse_gen.sv
// Synthetic detector pulses: triggered steps into an exponentially decaying accumulator, optional noise (V12_PULSE_GEN_NOISE_EN).
// Latency: trigger accepted in cycle n appears on output_data and pulse_start in cycle n+2.
// Backpressure: trig_ready drops for HOLDOFF cycles after every accepted (external or periodic) trigger.
module v12_pulse_gen
    import v12_pulse_gen_parameters::pg_state_t,
           v12_pulse_gen_parameters::IDLE,
           v12_pulse_gen_parameters::ACTIVE;
#(
    parameter int SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA,
    parameter int FRAC_BITS     = v12_pulse_gen_parameters::FRAC_BITS,
    parameter int DECAY_SHIFT   = v12_pulse_gen_parameters::DECAY_SHIFT,
    parameter int BASELINE      = v12_pulse_gen_parameters::BASELINE,
    parameter int HOLDOFF       = v12_pulse_gen_parameters::HOLDOFF,
    parameter int PERIOD_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig_valid,
    output logic                     trig_ready,
    input  logic [SIZE_ADC_DATA-1:0] trig_amp,
    input  logic                     period_en,
    input  logic [PERIOD_W-1:0]      period,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic                     pulse_start,
    output logic                     busy
);

    localparam int ACC_W  = SIZE_ADC_DATA + FRAC_BITS;
    localparam int HOLD_W = $clog2(HOLDOFF + 2);
    localparam int SUM_W  = SIZE_ADC_DATA + 3;

    localparam logic [HOLD_W-1:0]        HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic signed [SUM_W-1:0]  BASE_S    = SUM_W'(BASELINE);
    localparam logic signed [SUM_W-1:0]  MAX_S     = SUM_W'((1 << SIZE_ADC_DATA) - 1);
    localparam logic [SIZE_ADC_DATA-1:0] OUT_RST   = SIZE_ADC_DATA'(BASELINE);

    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         acc_next;
    logic [ACC_W-1:0]         dec;
    logic [ACC_W-1:0]         decayed;
    logic [ACC_W:0]           sum_ext;
    logic [HOLD_W-1:0]        holdoff_cnt;
    logic [PERIOD_W-1:0]      period_cnt;
    logic [SIZE_ADC_DATA-1:0] amp_reg;
    logic                     step_pending;
    logic                     ext_accept;
    logic                     period_on;
    logic                     period_wrap;
    logic                     trig_fire;
    logic signed [SUM_W-1:0]  out_sum;
    logic [SIZE_ADC_DATA-1:0] out_clamped;
    pg_state_t                state;
    pg_state_t                state_next;

    // A periodic wrap that lands inside the holdoff window is simply dropped.
    assign trig_ready  = (holdoff_cnt == '0);
    assign ext_accept  = trig_valid & trig_ready;
    assign period_on   = period_en & (period != '0);
    assign period_wrap = period_on & (period_cnt >= (period - PERIOD_W'(1)));
    assign trig_fire   = trig_ready & (trig_valid | period_wrap);
    assign busy        = (state == ACTIVE);

    // Decay with a minimum step of 1 so the tail always reaches exactly zero; saturate on pile-up.
    always_comb begin
        dec = acc >> DECAY_SHIFT;
        if ((dec == '0) && (acc != '0)) begin
            dec = ACC_W'(1);
        end
        decayed  = acc - dec;
        sum_ext  = {1'b0, decayed} + (step_pending ? {1'b0, amp_reg, {FRAC_BITS{1'b0}}} : '0);
        acc_next = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end

`ifdef V12_PULSE_GEN_NOISE_EN
    logic [15:0] lfsr_state;

    v12_lfsr16 #(
        .SEED (16'hACE1)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .state (lfsr_state)
    );

    // Output code = baseline + integer part + noise in [-4,+3], clamped to the ADC range.
    always_comb begin
        out_sum = BASE_S + $signed({3'b000, acc_next[ACC_W-1:FRAC_BITS]})
                + $signed({{(SUM_W-3){1'b0}}, lfsr_state[2:0]}) - SUM_W'(4);
        if (out_sum[SUM_W-1]) begin
            out_clamped = '0;
        end else if (out_sum > MAX_S) begin
            out_clamped = '1;
        end else begin
            out_clamped = out_sum[SIZE_ADC_DATA-1:0];
        end
    end
`else
    // Output code = baseline + integer part, clamped to the ADC range.
    always_comb begin
        out_sum = BASE_S + $signed({3'b000, acc_next[ACC_W-1:FRAC_BITS]});
        if (out_sum[SUM_W-1]) begin
            out_clamped = '0;
        end else if (out_sum > MAX_S) begin
            out_clamped = '1;
        end else begin
            out_clamped = out_sum[SIZE_ADC_DATA-1:0];
        end
    end
`endif

    // Trigger handshake, holdoff and periodic counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            holdoff_cnt  <= '0;
            period_cnt   <= '0;
            amp_reg      <= '0;
            step_pending <= 1'b0;
        end else begin
            step_pending <= trig_fire;
            if (ext_accept) begin
                amp_reg <= trig_amp;
            end
            if (trig_fire) begin
                holdoff_cnt <= HOLD_LOAD;
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - HOLD_W'(1);
            end
            if (!period_on || period_wrap) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end
        end
    end

    // Accumulator and output registers move together so the step and its strobe line up.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc         <= '0;
            output_data <= OUT_RST;
            pulse_start <= 1'b0;
        end else begin
            acc         <= acc_next;
            output_data <= out_clamped;
            pulse_start <= step_pending;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ACTIVE exactly while the accumulator holds charge; a zero-amplitude step stays IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (step_pending && (acc_next != '0)) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (acc_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_v12_pulse_gen.sv
// Self-checking bench for v12_pulse_gen (default build: noise off).
// Latency: n/a.
// Backpressure: n/a.
module tb_v12_pulse_gen;

    localparam int ACC_MAX  = (1 << 20) - 1;
    localparam int CODE_MAX = 4095;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig_valid;
    logic        trig_ready;
    logic [11:0] trig_amp;
    logic        period_en;
    logic [15:0] period;
    logic [11:0] output_data;
    logic        pulse_start;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model: charge in 1/256 code units, countdown to ready, pending step.
    int m_acc   = 0;
    int m_amp   = 0;
    int m_hold  = 0;
    int m_pcnt  = 0;
    int m_out   = 0;
    bit m_pend  = 0;
    bit m_pulse = 0;
    bit m_busy  = 0;

    int hold_idx[$];
    int hold_exp[4] = '{0, 9, 18, 27};
    int pulse_cyc[$];
    int mx;
    bit coincided;

    always #5 clk = ~clk;

    v12_pulse_gen dut (
        .clk         (clk),
        .reset       (reset),
        .trig_valid  (trig_valid),
        .trig_ready  (trig_ready),
        .trig_amp    (trig_amp),
        .period_en   (period_en),
        .period      (period),
        .output_data (output_data),
        .pulse_start (pulse_start),
        .busy        (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        int  dec;
        int  na;
        bit  ext;
        bit  wrap;
        bit  fire;
        if (!reset) begin
            m_acc = 0; m_amp = 0; m_hold = 0; m_pcnt = 0;
            m_pend = 0; m_pulse = 0; m_busy = 0; m_out = 0;
            return;
        end
        ext  = trig_valid && (m_hold == 0);
        wrap = period_en && (period != 0) && (m_pcnt >= int'(period) - 1);
        fire = (m_hold == 0) && (trig_valid || wrap);
        dec  = m_acc / 16;
        if (dec == 0 && m_acc > 0) dec = 1;
        na = m_acc - dec + (m_pend ? m_amp * 256 : 0);
        if (na > ACC_MAX) na = ACC_MAX;
        m_acc   = na;
        m_out   = (na / 256 > CODE_MAX) ? CODE_MAX : na / 256;
        m_pulse = m_pend;
        m_busy  = (na != 0);
        m_pend  = fire;
        if (ext) m_amp = int'(trig_amp);
        m_hold  = fire ? 8 : ((m_hold > 0) ? m_hold - 1 : 0);
        if (!(period_en && period != 0) || wrap) m_pcnt = 0;
        else m_pcnt++;
    endtask

    task automatic compare();
        check("output_data", int'(output_data), m_out);
        check("pulse_start", int'(pulse_start), int'(m_pulse));
        check("busy",        int'(busy),        int'(m_busy));
        check("trig_ready",  int'(trig_ready),  (m_hold == 0) ? 1 : 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic wait_idle(input string name, input int bound);
        int i = 0;
        trig_valid = 1'b0;
        while (busy && i < bound) begin
            tick();
            i++;
        end
        check({name, " settles idle"}, int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; trig_valid = 1'b0; trig_amp = '0; period_en = 1'b0; period = '0;
        #1;
        repeat (3) tick();
        check("reset output_data", int'(output_data), 0);
        check("reset trig_ready",  int'(trig_ready),  1);
        check("reset busy",        int'(busy),        0);
        check("reset pulse_start", int'(pulse_start), 0);
        reset = 1'b1;
        tick();

        // Single pulse, amplitude 1000.
        trig_amp = 12'd1000; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        tick();
        check("single n+2 data",  int'(output_data), 1000);
        check("single n+2 pulse", int'(pulse_start), 1);
        tick();
        check("single n+3 data",  int'(output_data), 937);
        check("single n+3 pulse", int'(pulse_start), 0);
        tick();
        check("single n+4 data",  int'(output_data), 878);
        wait_idle("single", 400);
        check("single tail zero", int'(output_data), 0);

        // Held trigger: one accept per HOLDOFF+1 cycles.
        trig_amp = 12'd100; trig_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (trig_ready) hold_idx.push_back(i);
            tick();
        end
        trig_valid = 1'b0;
        check("holdoff accept count", hold_idx.size(), 4);
        for (int k = 0; k < 4; k++)
            check("holdoff accept cycle", (k < hold_idx.size()) ? hold_idx[k] : -1, hold_exp[k]);
        wait_idle("holdoff", 400);

        // Pile-up saturates instead of wrapping.
        trig_amp = 12'd3000; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        repeat (8) tick();
        check("pileup ready at +9", int'(trig_ready), 1);
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        mx = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int'(output_data) > mx) mx = int'(output_data);
        end
        check("pileup clamp", mx, 4095);
        wait_idle("pileup", 400);

        // Periodic triggering with an external accept on the second wrap.
        trig_amp = 12'd500; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        repeat (3) tick();
        period = 16'd100; period_en = 1'b1;
        coincided = 1'b0;
        for (int i = 0; i < 450; i++) begin
            if (!coincided && i > 150 && m_pcnt == 99 && m_hold == 0) begin
                trig_valid = 1'b1; trig_amp = 12'd200; coincided = 1'b1;
            end
            tick();
            trig_valid = 1'b0;
            if (pulse_start) begin
                pulse_cyc.push_back(cyc);
                if (pulse_cyc.size() == 1)
                    check("periodic first step", (output_data >= 500 && output_data <= 501) ? 1 : 0, 1);
            end
        end
        check("periodic coincidence scheduled", int'(coincided), 1);
        check("periodic pulse count", pulse_cyc.size(), 4);
        for (int k = 1; k < pulse_cyc.size(); k++)
            check("periodic spacing", pulse_cyc[k] - pulse_cyc[k-1], 100);
        period_en = 1'b0;
        wait_idle("periodic", 400);

        // Zero amplitude still counts as a trigger.
        trig_amp = 12'd0; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        check("amp0 holdoff", int'(trig_ready), 0);
        tick();
        check("amp0 pulse", int'(pulse_start), 1);
        check("amp0 data",  int'(output_data), 0);
        check("amp0 busy",  int'(busy), 0);
        repeat (10) tick();

        // Reset mid-pulse clears everything on one edge.
        trig_amp = 12'd900; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        tick();
        check("prereset data",  int'(output_data), 900);
        check("prereset ready", int'(trig_ready), 0);
        reset = 1'b0;
        tick();
        check("midreset data",  int'(output_data), 0);
        check("midreset busy",  int'(busy), 0);
        check("midreset ready", int'(trig_ready), 1);
        check("midreset pulse", int'(pulse_start), 0);
        reset = 1'b1;
        tick();
        check("postreset data", int'(output_data), 0);
        check("postreset busy", int'(busy), 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/v12_pulse_gen.md
Name: v12_pulse_gen

Overview:
Synthetic detector-pulse source for the v12 shaping-filter chain. It produces ADC-format samples on the same bus width the filter consumes. Each accepted trigger adds an instantaneous step of programmable amplitude to an exponentially decaying accumulator, with pile-up allowed. The block replaces the ADC on the bench and in on-chip self-test, so filter response can be checked against known step/decay inputs.

Parameters:
SIZE_ADC_DATA, 12, output sample width; matches the filter input width.
FRAC_BITS, 8, fractional bits kept in the decay accumulator.
DECAY_SHIFT, 4, per-cycle decay: acc -= acc >> DECAY_SHIFT (tau ≈ 2^DECAY_SHIFT cycles).
BASELINE, 0, constant offset added to every output sample.
HOLDOFF, 8, minimum idle cycles after an accepted trigger before the next can be accepted.
PERIOD_W, 16, width of the periodic-trigger interval.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
trig_valid  input  1  trigger request
trig_ready  output  1  trigger can be accepted this cycle
trig_amp  input  SIZE_ADC_DATA  step amplitude, sampled on accept
period_en  input  1  enable internal periodic triggering
period  input  PERIOD_W  periodic interval in cycles; 0 = periodic off
output_data  output  SIZE_ADC_DATA  ADC-format sample
pulse_start  output  1  one-cycle strobe, aligned with the step appearing on output_data
busy  output  1  accumulator non-zero

Behaviour:
- Interface: reset reset, synchronous, active-low; clock clk.
- Reset (reset=0 at a clk edge): acc=0, holdoff_cnt=0, period_cnt=0, amp_reg=0, state=IDLE, output_data=BASELINE, pulse_start=0, busy=0. After reset, trig_ready=1.
  - Reset asserted mid-pulse clears everything on the same edge; no residual decay.
- Accumulator: acc is unsigned, SIZE_ADC_DATA+FRAC_BITS wide; integer part = acc[top:FRAC_BITS].
- Handshake: accept = trig_valid & trig_ready.
  - trig_ready = (holdoff_cnt==0), combinational.
  - On accept: amp_reg <= trig_amp, holdoff_cnt <= HOLDOFF.
  - holdoff_cnt decrements to 0 each cycle.
  - Holding trig_valid high gives one accept every HOLDOFF+1 cycles.
- Periodic source: when period_en=1 and period!=0, period_cnt counts 0..period-1.
  - At wrap, an internal trigger fires with amplitude amp_reg (last accepted amplitude).
  - The internal trigger is subject to the same holdoff.
  - If an external accept and a periodic wrap occur in the same cycle, one step only (the external amplitude) is applied.
- Update each cycle (cycle after accept):
  - acc_next = acc - dec + (fire ? amp_reg<<FRAC_BITS : 0).
  - dec = acc>>DECAY_SHIFT, or 1 if that is 0 and acc!=0, which guarantees return to exactly 0.
  - The sum saturates at all-ones; no wrap.
- Output register: output_data <= min(BASELINE + acc_int, 2^SIZE_ADC_DATA-1).
- Latency: external accept at cycle n → step visible on output_data at n+2; pulse_start high in cycle n+2.
- State machine: IDLE (acc==0) → ACTIVE on fire; ACTIVE → IDLE when acc_next==0 and no fire. busy = (state==ACTIVE).
- Amplitude 0 accept: counts as a trigger (holdoff loaded, pulse_start asserted) but acc is unchanged.

Optional Feature:
Macro V12_PULSE_GEN_NOISE_EN.
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) adds signed noise in [-4,+3] (LFSR[2:0] minus 4) to the output sum before clamping. The result clamps at 0 and at the maximum code.
- Undefined: no LFSR logic and output is noise-free.

Decomposition:
- Package v12_pulse_gen_parameters holds:
  - default constants FRAC_BITS, DECAY_SHIFT, HOLDOFF, BASELINE;
  - typedef enum logic {IDLE, ACTIVE} pg_state_t;
  - typedef logic [SIZE_ADC_DATA+FRAC_BITS-1:0] pg_acc_t.
- SIZE_ADC_DATA comes from package_settings.
- Optional sub-module v12_lfsr16 (seeded, enable input), instantiated only under V12_PULSE_GEN_NOISE_EN.

Test Plan (defaults, noise off):
- Reset held 3 cycles → output_data=0, trig_ready=1, busy=0, pulse_start=0.
- Single trigger amp=1000 accepted at cycle n → output_data at n+2,n+3,n+4 = 1000, 937, 878; pulse_start at n+2 only; busy falls after acc decays to 0.
- trig_valid held high for 30 cycles, amp=100 → accepts at cycles 0, 9, 18, 27; trig_ready low for 8 cycles after each accept.
- Pile-up: amp=3000 accepted, then amp=3000 accepted 9 cycles later → output_data clamps at 4095, no wrap.
- period_en=1, period=100, amp_reg=500 → pulse_start every 100 cycles; each step adds 500 to the decayed residue. An external accept coinciding with a wrap produces a single step.
- Reset dropped while output_data=900 → next cycle output_data=0, busy=0, holdoff cleared.
